alu_result_pipe: RTL and testbench



---
 rtl/alu_result_pipe_pkg.sv | 8 +
 rtl/alu_result_stage.sv | 40 ++++
 rtl/alu_result_pipe.sv | 90 +++++++++
 tb/tb_alu_result_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_pipe_pkg.sv
// Shared constants for ALU result handling: default result width and the
// position of the derived flags next to the stored result.
package alu_result_pipe_pkg;
  localparam int RES_W_DEFAULT = 32;
  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_NEG      = 1;
  localparam int NUM_FLAGS     = 2;
endpackage

// File: rtl/alu_result_stage.sv
// One elastic stage: a valid bit plus a payload register.
// A load wins over a clear; the payload changes only on load.
module alu_result_stage #(
  parameter int PW = 34
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          clr_i,
  input  logic [PW-1:0] d_i,
  output logic          valid_o,
  output logic [PW-1:0] q_o
);
  logic          valid_q, valid_d;
  logic [PW-1:0] pay_q, pay_d;

  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (load_i) begin
      valid_d = 1'b1;
      pay_d   = d_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = pay_q;
endmodule

// File: rtl/alu_result_pipe.sv
// Elastic DEPTH-stage result register with zero/neg flags, bubble collapsing,
// flush and registered occupancy count.
module alu_result_pipe
  import alu_result_pipe_pkg::*;
#(
  parameter int WIDTH = RES_W_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PW    = WIDTH + NUM_FLAGS;

  logic [DEPTH-1:0]         vld, mv, ld, clr, vld_nxt;
  logic [DEPTH-1:0][PW-1:0] stage_q;
  logic [DEPTH-1:0][PW-1:0] stage_d;
  logic [PW-1:0]            in_pay;
  logic                     accept;
  logic [CNT_W-1:0]         occ_q, occ_d;

  always_comb begin
    in_pay                  = '0;
    in_pay[PW-1:NUM_FLAGS]  = in_data;
    in_pay[FLAG_ZERO]       = ~|in_data;
    in_pay[FLAG_NEG]        = in_data[WIDTH-1];
  end

  // Move chain runs from the output backwards: a stage may advance when the
  // next one is empty or is itself advancing (bubble collapsing).
  always_comb begin
    mv          = '0;
    mv[DEPTH-1] = vld[DEPTH-1] & out_ready;
    for (int i = DEPTH-2; i >= 0; i--)
      mv[i] = vld[i] & (~vld[i+1] | mv[i+1]);
  end

  assign in_ready = ~vld[0] | mv[0];
  assign accept   = in_valid & in_ready;

  always_comb begin
    ld    = '0;
    ld[0] = accept & ~flush;
    for (int i = 1; i < DEPTH; i++)
      ld[i] = mv[i-1] & ~flush;
    clr     = mv | {DEPTH{flush}};
    vld_nxt = ld | (vld & ~clr);
    occ_d   = '0;
    for (int i = 0; i < DEPTH; i++)
      occ_d = occ_d + CNT_W'(vld_nxt[i]);
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign stage_d[g] = in_pay;
    end else begin : g_rest
      assign stage_d[g] = stage_q[g-1];
    end
    alu_result_stage #(.PW(PW)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .load_i  (ld[g]),
      .clr_i   (clr[g]),
      .d_i     (stage_d[g]),
      .valid_o (vld[g]),
      .q_o     (stage_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = stage_q[DEPTH-1][PW-1:NUM_FLAGS];
  assign out_zero  = stage_q[DEPTH-1][FLAG_ZERO];
  assign out_neg   = stage_q[DEPTH-1][FLAG_NEG];
  assign occupancy = occ_q;
endmodule

// File: tb/tb_alu_result_pipe.sv
// Bench for alu_result_pipe: DEPTH=2 instance with an output scoreboard and a
// DEPTH=1 instance compared against a plain one-cycle register.
module tb_alu_result_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, out_zero, out_neg;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  logic         d1_flush, d1_in_valid, d1_out_ready;
  logic [W-1:0] d1_in_data;
  logic         d1_in_ready, d1_out_valid, d1_out_zero, d1_out_neg;
  logic [W-1:0] d1_out_data;
  logic [0:0]   d1_occupancy;

  alu_result_pipe #(.WIDTH(W), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_neg(out_neg), .occupancy(occupancy)
  );

  alu_result_pipe #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .flush(d1_flush),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
    .out_zero(d1_out_zero), .out_neg(d1_out_neg), .occupancy(d1_occupancy)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         z;
    logic         n;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_pop = 0;

  function automatic exp_t mk(input logic [W-1:0] v);
    exp_t r;
    r.d = v;
    r.z = (v == '0);
    r.n = v[W-1];
    return r;
  endfunction

  // Scoreboard: push on accepted input, pop and compare on output transfer.
  always @(negedge clk) begin
    if (reset || flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got data=%h, none expected", out_data);
        end else begin
          e = q.pop_front();
          n_pop++;
          if ({out_data, out_zero, out_neg} !== {e.d, e.z, e.n}) begin
            n_fail++;
            $display("FAIL sb_data: got %h z%b n%b, expected %h z%b n%b",
                     out_data, out_zero, out_neg, e.d, e.z, e.n);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(mk(in_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b1;
    d1_flush = 1'b0; d1_in_valid = 1'b1; d1_in_data = 32'hFFFF_FFFF; d1_out_ready = 1'b1;
    tick(); tick();
    n_chk++;
    if ({out_valid, out_zero, out_neg} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got v%b z%b n%b, expected 000", out_valid, out_zero, out_neg);
    end
    n_chk++;
    if (out_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h, expected 0", out_data);
    end
    n_chk++;
    if (occupancy !== 2'd0) begin
      n_fail++; $display("FAIL reset_occ: got %0d, expected 0", occupancy);
    end
    n_chk++;
    if ({d1_out_valid, d1_out_data, d1_occupancy} !== '0) begin
      n_fail++; $display("FAIL reset_d1: got v%b %h occ%0d, expected all 0", d1_out_valid, d1_out_data, d1_occupancy);
    end
    reset = 1'b0; in_valid = 1'b0; d1_in_valid = 1'b0;
    tick();
    n_chk++;
    if ({in_ready, d1_in_ready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_in_ready: got %b%b, expected 11", in_ready, d1_in_ready);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] vals [3];
    logic [1:0]   flg  [3];
    logic [1:0]   occ  [3];
    vals[0] = 32'd5; vals[1] = 32'd0; vals[2] = 32'h8000_0000;
    flg[0] = 2'b00; flg[1] = 2'b10; flg[2] = 2'b01;
    occ[0] = 2'd2; occ[1] = 2'd2; occ[2] = 2'd1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = vals[0];
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL stream_first_edge: got v%b occ%0d, expected v0 occ1", out_valid, occupancy);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) in_data = vals[i+1];
      else       in_valid = 1'b0;
      tick();
      n_chk++;
      if ({out_valid, out_data, out_zero, out_neg, occupancy} !== {1'b1, vals[i], flg[i], occ[i]}) begin
        n_fail++;
        $display("FAIL stream_%0d: got v%b %h z%b n%b occ%0d, expected v1 %h zn%b occ%0d",
                 i, out_valid, out_data, out_zero, out_neg, occupancy, vals[i], flg[i], occ[i]);
      end
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h8000_0000) begin
      n_fail++; $display("FAIL stream_drain: got v%b %h occ%0d, expected v0 80000000 occ0", out_valid, out_data, occupancy);
    end
  endtask

  task automatic test_backpressure();
    int pop0;
    pop0 = n_pop;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd1;
    tick();
    in_data = 32'd2;
    tick();
    in_data = 32'd3;
    n_chk++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
      n_fail++; $display("FAIL bp_full: got in_ready=%b occ%0d, expected 0 and 2", in_ready, occupancy);
    end
    tick();
    n_chk++;
    if (out_data !== 32'd1 || out_valid !== 1'b1 || occupancy !== 2'd2) begin
      n_fail++; $display("FAIL bp_hold: got v%b %h occ%0d, expected v1 1 occ2", out_valid, out_data, occupancy);
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_through: got in_ready=%b, expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_chk++;
    if (n_pop - pop0 !== 3 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_count: got %0d results v%b, expected 3 and v0", n_pop - pop0, out_valid);
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd9;
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL bubble_s0: got v%b rdy%b occ%0d, expected v0 rdy1 occ1", out_valid, in_ready, occupancy);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 32'd9 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL bubble_s1: got v%b %h rdy%b occ%0d, expected v1 9 rdy1 occ1",
                         out_valid, out_data, in_ready, occupancy);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    in_data = 32'hC; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'hA) begin
      n_fail++; $display("FAIL flush_full: got v%b %h occ%0d, expected v0 0000000a occ0", out_valid, out_data, occupancy);
    end
    in_valid = 1'b1; in_data = 32'hD; flush = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_in_ready: got %b, expected 1", in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
        n_fail++; $display("FAIL flush_discard_%0d: got v%b %h occ%0d, expected v0 occ0", i, out_valid, out_data, occupancy);
      end
      tick();
    end
  endtask

  task automatic test_depth1();
    logic [W-1:0] v;
    d1_out_ready = 1'b1;
    d1_in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      v = $urandom;
      if (i == 3) v = '0;
      if (i == 5) v = 32'h8000_0000;
      d1_in_data = v;
      tick();
      n_chk++;
      if ({d1_out_valid, d1_out_data, d1_out_zero, d1_out_neg, d1_occupancy} !==
          {1'b1, v, (v == '0), v[W-1], 1'b1}) begin
        n_fail++;
        $display("FAIL depth1_%0d: got v%b %h z%b n%b occ%0d, expected v1 %h z%b n%b occ1",
                 i, d1_out_valid, d1_out_data, d1_out_zero, d1_out_neg, d1_occupancy, v, (v == '0), v[W-1]);
      end
    end
    d1_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_depth1();
    tick();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d pending results, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
